mem_arbiter: RTL

Shares the single main-memory word port between I-cache line refills and D-cache line refills/write-backs, so the pipeline can stall on ihit/dhit misses.
- Grants one requester per line transaction.
- Sequences LINE_WORDS word beats with a per-beat ready handshake.
- Signals line completion back to the granted cache.
- Sits between the two cache controllers and the memory model, below the mips core.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the main-memory word port between I-cache refills and D-cache refills/write-backs.
// Optional macro ARB_RR_EN: round-robin tie-break instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ic_req_i,
  input  logic [31:0]                   ic_addr_i,
  output logic                          ic_rvalid_o,
  output logic                          ic_done_o,
  input  logic                          dc_req_i,
  input  logic                          dc_we_i,
  input  logic [31:0]                   dc_addr_i,
  input  logic [31:0]                   dc_wdata_i,
  output logic                          dc_wready_o,
  output logic                          dc_rvalid_o,
  output logic                          dc_done_o,
  output logic [31:0]                   rdata_o,
  output logic [$clog2(LINE_WORDS)-1:0] beat_o,
  output logic                          busy_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [31:0]                   mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  input  logic                          mem_ready_i,
  input  logic [31:0]                   mem_rdata_i,
  output logic [1:0]                    state_o
);

  localparam int BEAT_W   = $clog2(LINE_WORDS);
  localparam int OFFSET_W = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  // Memory handshake: a beat transfers in any GRANT cycle where mem_req_o and
  // mem_ready_i are both high; every output holds steady while ready is low.

  state_t                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q;
  logic [31:OFFSET_W]     base_q;
  logic                   we_q;
  logic                   gnt_d_q;
  logic                   pick_d;
  logic                   grant_now;
  logic                   in_grant;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^{ic_addr_i[OFFSET_W-1:0], dc_addr_i[OFFSET_W-1:0]};
  assign grant_now = (state_q == IDLE) && (dc_req_i || ic_req_i);
  assign in_grant  = (state_q == GRANT_I) || (state_q == GRANT_D);

`ifdef ARB_RR_EN
  logic last_d_q;

  // A tie goes to whichever side was not granted last; reset value means I.
  assign pick_d = dc_req_i && (!ic_req_i || !last_d_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_d_q <= 1'b0;
    end else if (grant_now) begin
      last_d_q <= pick_d;
    end
  end
`else
  assign pick_d = dc_req_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             if (grant_now) state_d = pick_d ? GRANT_D : GRANT_I;
      GRANT_I, GRANT_D: if (mem_ready_i && beat_q == LAST_BEAT) state_d = DONE;
      DONE:             state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Line base, direction and owner are frozen at grant; later input changes are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      gnt_d_q <= 1'b0;
    end else begin
      if (grant_now) begin
        base_q  <= pick_d ? dc_addr_i[31:OFFSET_W] : ic_addr_i[31:OFFSET_W];
        we_q    <= pick_d && dc_we_i;
        gnt_d_q <= pick_d;
      end
      if (in_grant && mem_ready_i) begin
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    mem_req_o   = in_grant;
    mem_we_o    = in_grant && we_q;
    mem_addr_o  = in_grant ? {base_q, beat_q, 2'b00} : 32'h0;
    mem_wdata_o = (state_q == GRANT_D && we_q) ? dc_wdata_i : 32'h0;
    rdata_o     = in_grant ? mem_rdata_i : 32'h0;
    ic_rvalid_o = (state_q == GRANT_I) && mem_ready_i;
    dc_rvalid_o = (state_q == GRANT_D) && !we_q && mem_ready_i;
    dc_wready_o = (state_q == GRANT_D) && we_q && mem_ready_i;
    ic_done_o   = (state_q == DONE) && !gnt_d_q;
    dc_done_o   = (state_q == DONE) && gnt_d_q;
    busy_o      = (state_q != IDLE);
  end

  assign beat_o  = beat_q;
  assign state_o = state_q;

endmodule
